// File: rtl/tile_pixel_fetch.sv
// Five-stage tile-map pixel fetch: x/y -> map RAM -> tile ROM -> RGB444, with a frame-counter tile blink.
// Optional debug cell-grid overlay is compiled in when GRID_OVERLAY_EN is defined.
module tile_pixel_fetch #(
  parameter int          MAP_COLS   = 20,
  parameter int          MAP_ROWS   = 15,
  parameter logic [11:0] BG_COLOR   = 12'h000,
  parameter logic [3:0]  BLINK_TILE = 4'hF,
  parameter int          BLINK_LOG2 = 5
) (
  input  logic        clk_27,
  input  logic        rst,
  input  logic [11:0] x,
  input  logic [11:0] y,
  input  logic        de_i,
  input  logic        hs_i,
  input  logic        vs_i,
  output logic [8:0]  map_addr,
  input  logic [3:0]  map_rdata,
  output logic [13:0] read_address,
  input  logic [11:0] rgb_rdata,
  output logic [11:0] rgb_o,
  output logic        de_o,
  output logic        hs_o,
  output logic        vs_o
);

  localparam logic [12:0] X_LIM = 13'(32 * MAP_COLS);
  localparam logic [12:0] Y_LIM = 13'(32 * MAP_ROWS);

  logic       in_field;
  logic [8:0] map_addr_d;
  logic       frame_tick;

  // Stage 1/2 carry the in-cell offset alongside the map lookup.
  logic [4:0] tx1_q, ty1_q, tx2_q, ty2_q;
  logic       inf1_q, inf2_q, inf3_q, inf4_q;
  logic       blink3_q, blink4_q;
  logic [4:0] de_sr_q, hs_sr_q, vs_sr_q;
  logic [8:0] map_addr_q;
  logic [13:0] read_address_q;
  logic [11:0] rgb_q, rgb_d;
  logic [BLINK_LOG2:0] frame_q;
  logic       vs_prev_q;
`ifdef GRID_OVERLAY_EN
  logic       grid3_q, grid4_q;
`endif

  assign in_field   = de_i && ({1'b0, x} < X_LIM) && ({1'b0, y} < Y_LIM);
  assign map_addr_d = in_field ? 9'(16'(y[11:5]) * 16'(MAP_COLS) + 16'(x[11:5])) : 9'd0;
  assign frame_tick = vs_i && !vs_prev_q;

  // Priority: blanking, then out-of-field background, then overlay, then blink, then tile pixel.
  always_comb begin
    rgb_d = 12'h000;
    if (de_sr_q[3]) begin
      if (!inf4_q)
        rgb_d = BG_COLOR;
`ifdef GRID_OVERLAY_EN
      else if (grid4_q)
        rgb_d = 12'h444;
`endif
      else if (blink4_q)
        rgb_d = BG_COLOR;
      else
        rgb_d = rgb_rdata;
    end
  end

  always_ff @(posedge clk_27) begin
    if (rst) begin
      tx1_q          <= '0;
      ty1_q          <= '0;
      tx2_q          <= '0;
      ty2_q          <= '0;
      inf1_q         <= 1'b0;
      inf2_q         <= 1'b0;
      inf3_q         <= 1'b0;
      inf4_q         <= 1'b0;
      blink3_q       <= 1'b0;
      blink4_q       <= 1'b0;
      de_sr_q        <= '0;
      hs_sr_q        <= '0;
      vs_sr_q        <= '0;
      map_addr_q     <= '0;
      read_address_q <= '0;
      rgb_q          <= '0;
      frame_q        <= '0;
      vs_prev_q      <= 1'b0;
`ifdef GRID_OVERLAY_EN
      grid3_q        <= 1'b0;
      grid4_q        <= 1'b0;
`endif
    end else begin
      // Stage 1: map address and cell offset capture
      map_addr_q <= map_addr_d;
      tx1_q      <= x[4:0];
      ty1_q      <= y[4:0];
      inf1_q     <= in_field;
      // Stage 2: align with map RAM read data
      tx2_q      <= tx1_q;
      ty2_q      <= ty1_q;
      inf2_q     <= inf1_q;
      // Stage 3: tile ROM address; blink judged on the tile index seen here
      read_address_q <= {map_rdata, ty2_q, tx2_q};
      inf3_q         <= inf2_q;
      blink3_q       <= frame_q[BLINK_LOG2] && (map_rdata == BLINK_TILE);
      // Stage 4: align with tile ROM read data
      inf4_q   <= inf3_q;
      blink4_q <= blink3_q;
`ifdef GRID_OVERLAY_EN
      grid3_q  <= (tx2_q == 5'd0) || (ty2_q == 5'd0);
      grid4_q  <= grid3_q;
`endif
      // Stage 5
      rgb_q <= rgb_d;
      de_sr_q <= {de_sr_q[3:0], de_i};
      hs_sr_q <= {hs_sr_q[3:0], hs_i};
      vs_sr_q <= {vs_sr_q[3:0], vs_i};
      vs_prev_q <= vs_i;
      if (frame_tick)
        frame_q <= frame_q + 1'b1;
    end
  end

  assign map_addr     = map_addr_q;
  assign read_address = read_address_q;
  assign rgb_o        = rgb_q;
  assign de_o         = de_sr_q[4];
  assign hs_o         = hs_sr_q[4];
  assign vs_o         = vs_sr_q[4];

endmodule

// File: tb/tb_tile_pixel_fetch.sv
// Bench for tile_pixel_fetch: directed and random pixel streams, expected responses queued
// from a frame-level reference model and compared by an independent monitor.
module tb_tile_pixel_fetch;

  localparam int          COLS = 20;
  localparam int          ROWS = 15;
  localparam logic [11:0] BG   = 12'h0A5;
  localparam logic [3:0]  BLK  = 4'hF;

  typedef struct packed {
    logic        rst;
    logic [11:0] x;
    logic [11:0] y;
    logic        de;
    logic        hs;
    logic        vs;
  } pix_t;

  // clock / reset block
  logic        clk_27 = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] x = '0, y = '0;
  logic        de_i = 1'b0, hs_i = 1'b0, vs_i = 1'b0;
  logic [8:0]  map_addr;
  logic [3:0]  map_rdata = '0;
  logic [13:0] read_address;
  logic [11:0] rgb_rdata = '0;
  logic [11:0] rgb_o;
  logic        de_o, hs_o, vs_o;

  always #5 clk_27 = ~clk_27;

  tile_pixel_fetch #(.MAP_COLS(COLS), .MAP_ROWS(ROWS), .BG_COLOR(BG),
                     .BLINK_TILE(BLK), .BLINK_LOG2(5)) dut (
    .clk_27(clk_27), .rst(rst), .x(x), .y(y),
    .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
    .map_addr(map_addr), .map_rdata(map_rdata),
    .read_address(read_address), .rgb_rdata(rgb_rdata),
    .rgb_o(rgb_o), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o)
  );

  // Synchronous RAM / ROM behaviour with one cycle of read latency
  logic [3:0]  map_mem [512];
  logic [11:0] rom     [16384];

  always @(posedge clk_27) begin
    map_rdata <= map_mem[map_addr];
    rgb_rdata <= rom[read_address];
  end

  // reference model
  logic [14:0] exp_q[$];
  pix_t        hist_q[$];
  pix_t        pend;
  logic        have_pend = 1'b0;
  int          frames = 0;
  logic        prev_vs = 1'b0;
  int          n_vec = 0;
  int          n_err = 0;

  function automatic logic in_field(input pix_t p);
    return p.de && (int'(p.x) < 32 * COLS) && (int'(p.y) < 32 * ROWS);
  endfunction

  function automatic int cell_addr(input pix_t p);
    if (!in_field(p)) return 0;
    return ((int'(p.y) / 32) * COLS + int'(p.x) / 32) % 512;
  endfunction

  function automatic logic [3:0] tile_of(input pix_t p);
    return map_mem[cell_addr(p)];
  endfunction

  function automatic logic [14:0] expect_out(input pix_t p, input int cnt);
    logic [11:0] rgb;
    int          tx, ty;
    if (p.rst) return '0;
    tx = int'(p.x) % 32;
    ty = int'(p.y) % 32;
    if (!p.de)
      rgb = 12'h000;
    else if (!in_field(p))
      rgb = BG;
`ifdef GRID_OVERLAY_EN
    else if (tx == 0 || ty == 0)
      rgb = 12'h444;
`endif
    else if (tile_of(p) == BLK && cnt >= 32)
      rgb = BG;
    else
      rgb = rom[int'(tile_of(p)) * 1024 + ty * 32 + tx];
    return {rgb, p.de, p.hs, p.vs};
  endfunction

  // driver: one pixel per call; a pixel's blink state depends on the vs of the next pixel,
  // so each pixel's expectation is finalised one call later.
  task automatic drive(input logic r, input int xx, input int yy,
                       input logic d, input logic h, input logic v);
    pix_t p;
    @(negedge clk_27);
    p.rst = r; p.x = 12'(xx); p.y = 12'(yy); p.de = d; p.hs = h; p.vs = v;
    rst = r; x = p.x; y = p.y; de_i = d; hs_i = h; vs_i = v;
    hist_q.push_back(p);
    if (hist_q.size() > 8) void'(hist_q.pop_front());
    if (r) begin
      for (int i = 0; i < exp_q.size(); i++) exp_q[i] = '0;
      if (have_pend) exp_q.push_back('0);
      frames  = 0;
      prev_vs = 1'b0;
    end else begin
      if (v && !prev_vs) frames = (frames + 1) % 64;
      prev_vs = v;
      if (have_pend) exp_q.push_back(expect_out(pend, frames));
    end
    pend      = p;
    have_pend = 1'b1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor
  initial begin
    pix_t        h0, h1, h2;
    logic [14:0] e;
    forever begin
      @(posedge clk_27);
      #1;
      if (hist_q.size() > 0) begin
        h0 = hist_q[$];
        check("map_addr", 16'(map_addr), h0.rst ? 16'd0 : 16'(cell_addr(h0)));
        if (h0.rst) check("read_address_rst", 16'(read_address), 16'd0);
      end
      if (hist_q.size() >= 3) begin
        h0 = hist_q[$]; h1 = hist_q[$-1]; h2 = hist_q[$-2];
        if (!h0.rst && !h1.rst && !h2.rst)
          check("read_address", 16'(read_address), 16'({tile_of(h2), h2.y[4:0], h2.x[4:0]}));
      end
      if (exp_q.size() >= 4) begin
        e = exp_q.pop_front();
        check("rgb_o", 16'(rgb_o), 16'(e[14:3]));
        check("syncs", 16'({de_o, hs_o, vs_o}), 16'(e[2:0]));
      end
    end
  end

  initial begin
    for (int i = 0; i < 512; i++) map_mem[i] = 4'($urandom_range(0, 15));
    for (int i = 0; i < 16384; i++) rom[i] = 12'($urandom_range(0, 4095));
    map_mem[41] = 4'h3;
    map_mem[2]  = 4'hF;
    rom[14'h0CC5] = 12'hF80;

    // reset held three cycles with random inputs
    repeat (3) drive(1'b1, $urandom_range(0, 799), $urandom_range(0, 524),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // address path and pixel routing
    drive(1'b0, 37, 70, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 700, 70, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 37, 70, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 37, 70, 1'b1, 1'b0, 1'b0);

    // continuous line including the first out-of-field column
    for (int c = 0; c <= 640; c++) drive(1'b0, c, 5, 1'b1, 1'b0, 1'b0);

    // blink: 64 vs rising edges on a blinking tile, counter wraps back to 0
    drive(1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
    for (int f = 0; f < 64; f++) begin
      drive(1'b0, 70, 10, 1'b1, 1'b0, 1'b1);
      drive(1'b0, 70, 10, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 75, 12, 1'b1, 1'b0, 1'b0);
    end

    // grid corner pixel
    drive(1'b0, 64, 10, 1'b1, 1'b0, 1'b0);

    // mid-line reset
    for (int c = 100; c < 110; c++) drive(1'b0, c, 40, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 110, 40, 1'b1, 1'b0, 1'b0);
    for (int c = 111; c < 120; c++) drive(1'b0, c, 40, 1'b1, 1'b0, 1'b0);

    // random stream
    for (int i = 0; i < 3000; i++)
      drive(1'($urandom_range(0, 299) == 0), $urandom_range(0, 799), $urandom_range(0, 524),
            1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));

    repeat (8) drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    @(posedge clk_27);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tile_pixel_fetch.md
TILE_PIXEL_FETCH -- requirements
Module: tile_pixel_fetch

Interface
REQ-001 SHALL have parameter MAP_COLS, default 20, meaning playfield cells per row.
REQ-002 SHALL have parameter MAP_ROWS, default 15, meaning playfield cell rows.
REQ-003 SHALL have parameter BG_COLOR, default 12'h000, meaning colour outside the playfield.
REQ-004 SHALL have parameter BLINK_TILE, default 4'hF, meaning the tile index that blinks.
REQ-005 SHALL have parameter BLINK_LOG2, default 5, meaning the blink half-period is 2^BLINK_LOG2 frames.
REQ-006 SHALL have the following ports, one per line: name  direction  width  meaning.
- clk_27  in  1  sole clock; one pixel per cycle.
- rst  in  1  synchronous, active-high reset.
- x  in  12  pixel column from video timing.
- y  in  12  pixel row from video timing.
- de_i, hs_i, vs_i  in  1 each  data-enable and syncs aligned with x/y.
- map_addr  out  9  map RAM read address.
- map_rdata  in  4  tile index; 1-cycle synchronous RAM latency.
- read_address  out  14  tile ROM address {tile[3:0], ty[4:0], tx[4:0]}.
- rgb_rdata  in  12  tile ROM pixel; 1-cycle synchronous ROM latency.
- rgb_o  out  12  output pixel RGB444.
- de_o, hs_o, vs_o  out  1 each  delayed syncs aligned with rgb_o.

Function
REQ-007 Cells SHALL be 32x32 pixels; cell column = x[11:5], row = y[11:5], tx = x[4:0], ty = y[4:0].
REQ-008 A pixel SHALL be in-field when de_i=1, x < 32*MAP_COLS and y < 32*MAP_ROWS.
REQ-009 Stage 1 (T+1): map_addr SHALL register row*MAP_COLS+col, truncated to 9 bits; when not in-field it SHALL register 0.
REQ-010 Stage 2 (T+2): map_rdata is valid; tx, ty and the in-field flag SHALL be delayed two cycles to align with it.
REQ-011 Stage 3 (T+3): read_address SHALL register {map_rdata, ty, tx}.
REQ-012 Stage 4 (T+4): rgb_rdata is valid.
REQ-013 Stage 5 (T+5): rgb_o SHALL register one of the following.
- rgb_rdata when the pixel is in-field.
- BG_COLOR when the pixel is out-of-field and de=1.
- 12'h000 when de=0.
REQ-014 Total latency x/y -> rgb_o SHALL be exactly 5 cycles; de_o/hs_o/vs_o SHALL be de_i/hs_i/vs_i delayed exactly 5 cycles.
REQ-015 The pipeline SHALL accept one pixel per cycle with no stall or backpressure.
REQ-016 A frame counter (BLINK_LOG2+1 bits) SHALL increment on each vs_i rising edge (vs_i=1 and the previous sample=0) and wrap to 0 modulo 2^(BLINK_LOG2+1).
REQ-017 When the counter MSB=1 and the stage-3 tile index equals BLINK_TILE, that pixel SHALL output BG_COLOR at stage 5 instead of rgb_rdata.
REQ-018 A vs_i edge coincident with an active pixel SHALL affect only pixels entering stage 3 on or after the following cycle.

Reset
REQ-019 While rst=1 at a clk_27 edge, all pipeline registers, map_addr, read_address, rgb_o, de_o, hs_o, vs_o, the frame counter and the vs edge register SHALL clear to 0.
REQ-020 Asserting rst mid-line SHALL discard all in-flight pixels.
REQ-021 After rst deasserts, outputs SHALL carry valid data only 5 cycles after the first post-reset pixel; until then they SHALL be 0.

Configuration
REQ-022 Macro GRID_OVERLAY_EN SHALL control a debug cell-grid overlay.
- Defined: an in-field pixel with tx==0 or ty==0 SHALL output 12'h444 at stage 5, overriding tile colour and blink.
- Undefined: no overlay logic SHALL exist, and output SHALL follow REQ-013/REQ-017 only.

Verification
REQ-023 Reset check: hold rst 3 cycles with random inputs -> rgb_o, map_addr, read_address, de_o, hs_o and vs_o all 0.
REQ-024 Address path: x=37, y=70, de_i=1, map_rdata=4'h3 at T+2 -> map_addr=2*20+1=41 at T+1; read_address={4'h3,5'd6,5'd5}=14'h0CC5 at T+3.
REQ-025 Latency and pixel routing: rgb_rdata=12'hF80 at T+4 for an in-field pixel -> rgb_o=12'hF80 at T+5; the same pixel at x=700 -> BG_COLOR; de_i=0 -> 12'h000; de_o equals de_i delayed 5.
REQ-026 Blink: map_rdata=4'hF, drive 32 vs_i rising edges -> the tile pixel shows BG_COLOR; after 32 more edges -> it shows rgb_rdata again; after 64 edges the counter wraps to 0.
REQ-027 Back-to-back pixels: stream x=0..639 continuously -> rgb_o changes every cycle with no bubbles, and column 640 outputs BG_COLOR.
REQ-028 GRID_OVERLAY_EN defined: x=64, y=10 in-field -> rgb_o=12'h444; undefined -> the rgb_rdata value.
